// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment message path.
// Sequencer states and the blank glyph code.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHOW   = 2'd1,
    ST_SCROLL = 2'd2
  } state_t;

  localparam logic [7:0] BLANK_CHAR_DEF = 8'h20;
  localparam int         NUM_DIGITS     = 4;

endpackage

// File: rtl/seg7_scroll_ctrl_if.sv
// Character write port into the scroll sequencer.
// Transfer when WR_VALID and WR_READY are both high.
interface seg7_scroll_ctrl_if;

  logic       WR_VALID;
  logic [7:0] WR_CHAR;
  logic       WR_READY;

  modport master (
    output WR_VALID,
    output WR_CHAR,
    input  WR_READY
  );

  modport slave (
    input  WR_VALID,
    input  WR_CHAR,
    output WR_READY
  );

endinterface

// File: rtl/seg7_tick_gen.sv
// Scroll-rate divider: one-cycle step every TICK_DIV clocks.
// Held at zero while clear is asserted.
module seg7_tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clear,
  output logic step
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] cnt_q;

  assign step = !clear && (cnt_q == LAST);

  // free-running count, restarted by clear or after the last tick
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (clear || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/seg7_scroll_ctrl.sv
// Message buffer and window sequencer feeding Segment7.
// Short messages are static, longer ones scroll left.
module seg7_scroll_ctrl
  import seg7_pkg::*;
#(
  parameter int         MSG_DEPTH  = 16,
  parameter int         TICK_DIV   = 25000000,
  parameter logic [7:0] BLANK_CHAR = BLANK_CHAR_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  seg7_scroll_ctrl_if.slave wr,
  input  logic              START,
  input  logic              STOP,
  output logic              BUSY,
  output logic              WRAP_PULSE,
  output logic [7:0]        DATA1,
  output logic [7:0]        DATA2,
  output logic [7:0]        DATA3,
  output logic [7:0]        DATA4
);

  localparam int AW = $clog2(MSG_DEPTH);
  localparam int LW = AW + 1;
  localparam int OW = $clog2(MSG_DEPTH + NUM_DIGITS) + 1;

  logic [7:0]    mem [MSG_DEPTH];
  state_t        state_q;
  state_t        state_d;
  logic [LW-1:0] len_q;
  logic [LW-1:0] len_inc;
  logic [OW-1:0] ofs_q;
  logic [OW-1:0] ring_len;
  logic [OW-1:0] ring_last;
  logic          wr_fire;
  logic          step;
  logic          tick_clr;
  logic          busy_d;
  logic [OW-1:0] pos [NUM_DIGITS];
  logic [7:0]    win [NUM_DIGITS];

  assign wr.WR_READY = (state_q == ST_IDLE) &&
                       (len_q < LW'(MSG_DEPTH));
  assign wr_fire   = wr.WR_VALID && wr.WR_READY;
  assign len_inc   = wr_fire ? len_q + 1'b1 : len_q;
  assign ring_len  = OW'(len_q) + OW'(NUM_DIGITS);
  assign ring_last = ring_len - 1'b1;

  seg7_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clear (tick_clr),
    .step  (step)
  );

  // next state; a same-cycle write counts toward the START length
  always_comb begin
    state_d  = state_q;
    tick_clr = 1'b1;
    if (STOP) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (START && (len_inc != '0)) begin
            state_d = (len_inc <= LW'(NUM_DIGITS)) ?
                      ST_SHOW : ST_SCROLL;
          end
        end
        ST_SHOW:   state_d = ST_SHOW;
        ST_SCROLL: tick_clr = 1'b0;
        default:   state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // state and busy flag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      BUSY    <= 1'b0;
    end else begin
      state_q <= state_d;
      BUSY    <= busy_d;
    end
  end

  // message length; STOP empties the buffer
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      len_q <= '0;
    end else if (STOP) begin
      len_q <= '0;
    end else begin
      len_q <= len_inc;
    end
  end

  // character storage, appended at the current length
  always_ff @(posedge CLK) begin
    if (wr_fire) begin
      mem[len_q[AW-1:0]] <= wr.WR_CHAR;
    end
  end

  // scroll offset into the ring, wrap flagged for one cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ofs_q      <= '0;
      WRAP_PULSE <= 1'b0;
    end else begin
      WRAP_PULSE <= 1'b0;
      if (tick_clr) begin
        ofs_q <= '0;
      end else if (step) begin
        if (ofs_q == ring_last) begin
          ofs_q      <= '0;
          WRAP_PULSE <= 1'b1;
        end else begin
          ofs_q <= ofs_q + 1'b1;
        end
      end
    end
  end

  // window over message plus four trailing blanks
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      pos[i] = ofs_q + OW'(i);
      if (pos[i] >= ring_len) begin
        pos[i] = pos[i] - ring_len;
      end
      win[i] = BLANK_CHAR;
      if ((state_q != ST_IDLE) && (pos[i] < OW'(len_q))) begin
        win[i] = mem[pos[i][AW-1:0]];
      end
    end
  end

  // registered digit outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DATA1 <= BLANK_CHAR;
      DATA2 <= BLANK_CHAR;
      DATA3 <= BLANK_CHAR;
      DATA4 <= BLANK_CHAR;
    end else begin
      DATA1 <= win[0];
      DATA2 <= win[1];
      DATA3 <= win[2];
      DATA4 <= win[3];
    end
  end

endmodule

// File: tb/tb_seg7_scroll_ctrl.sv
// Bench for seg7_scroll_ctrl: directed and random messages
// checked against a ring-window reference every cycle.
module tb_seg7_scroll_ctrl;

  localparam int TD    = 4;
  localparam int DEPTH = 16;
  localparam logic [7:0] BL = 8'h20;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
  logic       BUSY;
  logic       WRAP_PULSE;
  logic [7:0] DATA1, DATA2, DATA3, DATA4;

  seg7_scroll_ctrl_if wif();

  seg7_scroll_ctrl #(
    .MSG_DEPTH  (DEPTH),
    .TICK_DIV   (TD),
    .BLANK_CHAR (BL)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .wr         (wif.slave),
    .START      (START),
    .STOP       (STOP),
    .BUSY       (BUSY),
    .WRAP_PULSE (WRAP_PULSE),
    .DATA1      (DATA1),
    .DATA2      (DATA2),
    .DATA3      (DATA3),
    .DATA4      (DATA4)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  byte unsigned msg[$];
  bit           run = 1'b0;
  int           c = 0;
  logic [31:0]  exp_data = {4{BL}};

  function automatic logic [31:0] window();
    logic [31:0] w;
    int L, n, p;
    w = {4{BL}};
    if (!run) return w;
    L = msg.size() + 4;
    n = (msg.size() > 4) ? ((c / TD) % L) : 0;
    for (int i = 0; i < 4; i++) begin
      p = (n + i) % L;
      w = {w[23:0], (p < msg.size()) ? msg[p] : BL};
    end
    return w;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input bit wrap);
    chk("data", {DATA1, DATA2, DATA3, DATA4}, exp_data);
    chk("wrap", {31'd0, WRAP_PULSE}, {31'd0, wrap});
    chk("busy", {31'd0, BUSY}, {31'd0, run});
    chk("ready", {31'd0, wif.WR_READY},
        {31'd0, (!run && msg.size() < DEPTH)});
  endtask

  task automatic cyc();
    bit v, s, p, rdy, wrap;
    byte unsigned ch;
    v  = wif.WR_VALID;
    ch = wif.WR_CHAR;
    s  = START;
    p  = STOP;
    @(posedge CLK);
    #1;
    exp_data = window();
    rdy = !run && (msg.size() < DEPTH);
    if (p) begin
      run = 1'b0;
      msg.delete();
      c = 0;
    end else begin
      if (v && rdy) msg.push_back(ch);
      if (run) c++;
      else if (s && msg.size() > 0) begin
        run = 1'b1;
        c = 0;
      end
    end
    wrap = run && (msg.size() > 4) && (c > 0) &&
           (c % (TD * (msg.size() + 4)) == 0);
    check_all(wrap);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic put(input byte unsigned ch);
    wif.WR_VALID = 1'b1;
    wif.WR_CHAR  = ch;
    cyc();
    wif.WR_VALID = 1'b0;
  endtask

  task automatic put_str(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i]);
  endtask

  task automatic put_rand(input int n);
    for (int i = 0; i < n; i++) put(8'($urandom_range(33, 126)));
  endtask

  task automatic pulse(input bit st, input bit sp);
    START = st;
    STOP  = sp;
    cyc();
    START = 1'b0;
    STOP  = 1'b0;
  endtask

  task automatic async_reset();
    #2 RST_N = 1'b0;
    #1;
    run = 1'b0;
    msg.delete();
    c = 0;
    exp_data = {4{BL}};
    check_all(1'b0);
    #3 RST_N = 1'b1;
  endtask

  initial begin
    wif.WR_VALID = 1'b0;
    wif.WR_CHAR  = 8'h00;
    #12;
    check_all(1'b0);
    RST_N = 1'b1;
    idle(2);

    put_str("AB");
    pulse(1'b1, 1'b0);
    idle(100);
    pulse(1'b0, 1'b1);
    idle(2);

    put_str("HELLO");
    pulse(1'b1, 1'b0);
    idle(4 * 9 + 8);
    pulse(1'b0, 1'b1);
    idle(2);

    put_rand(16);
    put(8'h51);
    pulse(1'b1, 1'b0);
    idle(4 * 20 + 6);

    put(8'h5A);
    idle(6);
    pulse(1'b1, 1'b1);
    idle(2);
    pulse(1'b1, 1'b0);
    idle(3);

    put_rand(7);
    pulse(1'b1, 1'b0);
    idle(13);
    async_reset();
    idle(2);
    pulse(1'b1, 1'b0);
    idle(3);

    wif.WR_VALID = 1'b1;
    wif.WR_CHAR  = 8'h58;
    pulse(1'b1, 1'b0);
    wif.WR_VALID = 1'b0;
    idle(3);
    pulse(1'b0, 1'b1);
    idle(2);
    put_str("1234");
    pulse(1'b1, 1'b0);
    idle(30);
    pulse(1'b0, 1'b1);
    idle(2);

    for (int t = 0; t < 6; t++) begin
      put_rand($urandom_range(1, 17));
      pulse(1'b1, 1'b0);
      idle($urandom_range(10, 100));
      pulse(($urandom_range(0, 1) == 1), 1'b1);
      idle(2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
